// File: rtl/proc_pkg.sv
// ============================================================================
// Module : proc_pkg
// Brief  : Shared opcodes, time-step encoding and IR field helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int IR_W = 9;
    localparam int NREG = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    function automatic logic [2:0] ir_opc(input logic [IR_W-1:0] ir);
        return ir[8:6];
    endfunction

    function automatic logic [2:0] ir_x(input logic [IR_W-1:0] ir);
        return ir[5:3];
    endfunction

    function automatic logic [2:0] ir_y(input logic [IR_W-1:0] ir);
        return ir[2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/proc_ctrl_dec3to8.sv
// ============================================================================
// Module : dec3to8
// Brief  : 3-to-8 register-select decoder with enable; bit 0 = R0.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dec3to8 (
    input  logic [2:0] W,
    input  logic       En,
    output logic [0:7] Y
);

    always_comb begin
        Y = '0;
        if (En) begin
            Y[W] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/proc_ctrl.sv
// ============================================================================
// Module : proc_ctrl
// Brief  : Processor control unit: IR latch and T0..T3 step sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module proc_ctrl
    import proc_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Run,
    input  logic [IR_W-1:0] Instr,
    output logic [0:7]      Rin,
    output logic [0:7]      Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            DINout,
    output logic            AddSub,
    output logic            Done,
    output logic [1:0]      Tstep
);

    tstep_t          r_state;
    tstep_t          w_next;
    logic [IR_W-1:0] r_ir;

    logic [2:0]      w_opc;
    logic            w_x_en;
    logic            w_y_en;
    logic            w_x_to_rin;
    logic            w_x_to_rout;
    logic [0:7]      w_xdec;
    logic [0:7]      w_ydec;

    assign w_opc = ir_opc(r_ir);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == T0 && Run) begin
                r_ir <= Instr;
            end
        end
    end

    // The X decoder feeds either Rin or Rout depending on step; Y only feeds Rout.
    always_comb begin
        w_next      = r_state;
        w_x_en      = 1'b0;
        w_y_en      = 1'b0;
        w_x_to_rin  = 1'b0;
        w_x_to_rout = 1'b0;
        Ain         = 1'b0;
        Gin         = 1'b0;
        Gout        = 1'b0;
        DINout      = 1'b0;
        AddSub      = 1'b0;
        Done        = 1'b0;
        case (r_state)
            T0: begin
                if (Run) begin
                    w_next = T1;
                end
            end
            T1: begin
                case (w_opc)
                    OP_MV: begin
                        w_y_en     = 1'b1;
                        w_x_en     = 1'b1;
                        w_x_to_rin = 1'b1;
                        Done       = 1'b1;
                        w_next     = T0;
                    end
                    OP_MVI: begin
                        DINout     = 1'b1;
                        w_x_en     = 1'b1;
                        w_x_to_rin = 1'b1;
                        Done       = 1'b1;
                        w_next     = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        w_x_en      = 1'b1;
                        w_x_to_rout = 1'b1;
                        Ain         = 1'b1;
                        w_next      = T2;
                    end
                    default: begin
                        Done   = 1'b1;
                        w_next = T0;
                    end
                endcase
            end
            T2: begin
                w_y_en = 1'b1;
                Gin    = 1'b1;
                AddSub = r_ir[6];
                w_next = T3;
            end
            T3: begin
                Gout       = 1'b1;
                w_x_en     = 1'b1;
                w_x_to_rin = 1'b1;
                Done       = 1'b1;
                w_next     = T0;
            end
            default: begin
                w_next = T0;
            end
        endcase
    end

    dec3to8 u_dec_x (
        .W  (ir_x(r_ir)),
        .En (w_x_en),
        .Y  (w_xdec)
    );

    dec3to8 u_dec_y (
        .W  (ir_y(r_ir)),
        .En (w_y_en),
        .Y  (w_ydec)
    );

    assign Rin   = w_x_to_rin  ? w_xdec : '0;
    assign Rout  = (w_x_to_rout ? w_xdec : '0) | w_ydec;
    assign Tstep = r_state;

endmodule

`default_nettype wire

// File: tb/tb_proc_ctrl.sv
// ============================================================================
// Module : tb_proc_ctrl
// Brief  : Scoreboard bench for proc_ctrl with a per-instruction step model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_proc_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Run;
    logic [8:0] Instr;
    logic [0:7] Rin;
    logic [0:7] Rout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       DINout;
    logic       AddSub;
    logic       Done;
    logic [1:0] Tstep;

    always #5 Clock = ~Clock;

    proc_ctrl dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .Instr  (Instr),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done),
        .Tstep  (Tstep)
    );

    typedef struct packed {
        logic [1:0] ts;
        logic [0:7] rin;
        logic [0:7] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic       addsub;
        logic       done;
    } rec_t;

    rec_t exp_q[$];
    rec_t pending[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    rec_t mon_act;
    rec_t mon_exp;

    function automatic logic [0:7] oh(input logic [2:0] r);
        logic [0:7] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Expected per-cycle outputs for every step after T0 of one instruction.
    task automatic expand(input logic [8:0] ins);
        rec_t       r;
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        op = ins[8:6];
        x  = ins[5:3];
        y  = ins[2:0];
        r  = '0;
        r.ts = 2'd1;
        if (op == 3'b000) begin
            r.rin = oh(x); r.rout = oh(y); r.done = 1'b1;
            pending.push_back(r);
        end else if (op == 3'b001) begin
            r.rin = oh(x); r.dinout = 1'b1; r.done = 1'b1;
            pending.push_back(r);
        end else if (op == 3'b010 || op == 3'b011) begin
            r.rout = oh(x); r.ain = 1'b1;
            pending.push_back(r);
            r = '0; r.ts = 2'd2;
            r.rout = oh(y); r.gin = 1'b1; r.addsub = (op == 3'b011);
            pending.push_back(r);
            r = '0; r.ts = 2'd3;
            r.gout = 1'b1; r.rin = oh(x); r.done = 1'b1;
            pending.push_back(r);
        end else begin
            r.done = 1'b1;
            pending.push_back(r);
        end
    endtask

    task automatic step(input bit rst_now, input bit run, input logic [8:0] ins);
        rec_t e;
        @(posedge Clock);
        #2;
        Reset = rst_now;
        Run   = run;
        Instr = ins;
        e     = '0;
        if (rst_now) begin
            pending.delete();
        end else if (pending.size() == 0) begin
            if (run) expand(ins);
        end else begin
            e = pending.pop_front();
        end
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    always @(negedge Clock) begin
        if (mon_en) begin
            mon_act = {Tstep, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow t=%0t: actual queue size 0, required >0", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL step_outputs t=%0t: actual ts=%0d rin=%b rout=%b ain=%b gin=%b gout=%b din=%b as=%b done=%b, required ts=%0d rin=%b rout=%b ain=%b gin=%b gout=%b din=%b as=%b done=%b",
                             $time, mon_act.ts, mon_act.rin, mon_act.rout, mon_act.ain, mon_act.gin,
                             mon_act.gout, mon_act.dinout, mon_act.addsub, mon_act.done,
                             mon_exp.ts, mon_exp.rin, mon_exp.rout, mon_exp.ain, mon_exp.gin,
                             mon_exp.gout, mon_exp.dinout, mon_exp.addsub, mon_exp.done);
                end
            end
            checks++;
            if ($countones({Rout, Gout, DINout}) > 1) begin
                errors++;
                $display("FAIL bus_drive_invariant t=%0t: actual rout=%b gout=%b din=%b, required at most one driver",
                         $time, Rout, Gout, DINout);
            end
            checks++;
            if (!$onehot0(Rin) || !$onehot0(Rout)) begin
                errors++;
                $display("FAIL select_onehot t=%0t: actual rin=%b rout=%b, required onehot0", $time, Rin, Rout);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        Instr = '0;
        step(1'b1, 1'b0, 9'd0);
        step(1'b1, 1'b0, 9'd0);
        step(1'b0, 1'b0, 9'd0);

        // mv R2,R5
        step(1'b0, 1'b1, 9'b000_010_101);
        step(1'b0, 1'b0, 9'd0);
        step(1'b0, 1'b0, 9'd0);
        // mvi R7
        step(1'b0, 1'b1, 9'b001_111_000);
        step(1'b0, 1'b0, 9'd0);
        // sub R1,R2
        step(1'b0, 1'b1, 9'b011_001_010);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'd0);
        // back-to-back add then mv with Run held; junk Instr in T2
        step(1'b0, 1'b1, 9'b010_011_100);
        step(1'b0, 1'b1, 9'b010_011_100);
        step(1'b0, 1'b1, 9'b111_111_111);
        step(1'b0, 1'b1, 9'b000_110_001);
        step(1'b0, 1'b1, 9'b000_110_001);
        step(1'b0, 1'b0, 9'd0);
        step(1'b0, 1'b0, 9'd0);
        // NOP opcode 101
        step(1'b0, 1'b1, 9'b101_011_110);
        step(1'b0, 1'b0, 9'd0);
        // add R3,R3
        step(1'b0, 1'b1, 9'b010_011_011);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'd0);
        // reset mid-T2 of add
        step(1'b0, 1'b1, 9'b010_001_001);
        step(1'b0, 1'b0, 9'd0);
        step(1'b1, 1'b0, 9'd0);
        step(1'b1, 1'b1, 9'b000_001_010);
        step(1'b0, 1'b0, 9'd0);
        step(1'b0, 1'b0, 9'd0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 9'($urandom));
        end
        step(1'b0, 1'b0, 9'd0);

        @(negedge Clock);
        #1;
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
